// File: rtl/pdp8_binload_if.sv
// pdp8_binload_if: byte-stream and RAM-write bundle of the BIN tape loader.
//   byte_in/byte_valid/byte_ready : 8-bit tape frame handshake
//   ram_addr/ram_data_out/ram_wr  : {field, address} write port into pdp8_ram
//   busy/done/cksum_ok/fmt_err    : loader status toward the CPU
//   words                         : number of data words written (mod 4096)
// slave  : the loader (consumes frames, drives RAM and status)
// master : the frame source / RAM / CPU side
interface pdp8_binload_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [14:0] ram_addr;
  logic [11:0] ram_data_out;
  logic        ram_wr;
  logic        busy;
  logic        done;
  logic        cksum_ok;
  logic        fmt_err;
  logic [11:0] words;

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, ram_addr, ram_data_out, ram_wr,
    output busy, done, cksum_ok, fmt_err, words
  );

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, ram_addr, ram_data_out, ram_wr,
    input  busy, done, cksum_ok, fmt_err, words
  );
endinterface

// File: rtl/pdp8_binload.sv
// pdp8_binload: PDP-8 BIN-format paper-tape loader feeding pdp8_ram.
// Decodes leader/trailer, field, origin and data frames, writes 12-bit
// words at {field, addr}, accumulates the BIN checksum and compares it with
// the last word before the trailer.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : pdp8_binload_if.slave (frame handshake, RAM write, status)
module pdp8_binload (
  input logic           clk,
  input logic           reset,
  pdp8_binload_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEADER = 3'd0,
    S_FRAME1 = 3'd1,
    S_FRAME2 = 3'd2,
    S_WRITE  = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // BIN checksum: plain 12-bit sum of both full 8-bit frames of a word.
  function automatic logic [11:0] cksum_add(input logic [11:0] sum,
                                            input logic [7:0]  b_hi,
                                            input logic [7:0]  b_lo);
    cksum_add = sum + {4'b0000, b_hi} + {4'b0000, b_lo};
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  field_q, field_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] cksum_q, cksum_d;
  logic [11:0] words_q, words_d;
  logic        ign_q, ign_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  // One completed word is always held back: it might be the checksum.
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_hi_q, pend_hi_d;
  logic [7:0]  pend_lo_q, pend_lo_d;
  logic [2:0]  pend_field_q, pend_field_d;
  logic        ram_wr_q, ram_wr_d;
  logic [14:0] ram_addr_q, ram_addr_d;
  logic [11:0] ram_data_q, ram_data_d;
  logic        byte_ready_q, byte_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cksum_ok_q, cksum_ok_d;
  logic        fmt_err_q, fmt_err_d;

  logic        accept;
  logic        is_rubout;
  logic        frame_take;
  logic        is_field;
  logic [1:0]  frame_cls;
  logic [11:0] pend_word;

  assign accept     = bus.byte_valid & byte_ready_q;
  assign is_rubout  = (bus.byte_in == 8'hFF);
  // Rubouts toggle the ignore flag and are themselves never decoded.
  assign frame_take = accept & ~is_rubout & ~ign_q;
  assign frame_cls  = bus.byte_in[7:6];
  assign is_field   = (frame_cls == 2'b11) && (bus.byte_in[2:0] == 3'b000);
  assign pend_word  = {pend_hi_q[5:0], pend_lo_q[5:0]};

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    field_d      = field_q;
    addr_d       = addr_q;
    cksum_d      = cksum_q;
    words_d      = words_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_valid_d = pend_valid_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_field_d = pend_field_q;
    ram_wr_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    cksum_ok_d   = cksum_ok_q;
    fmt_err_d    = fmt_err_q;
    ign_d        = (accept && is_rubout) ? ~ign_q : ign_q;

    case (state_q)
      S_LEADER, S_FRAME1: begin
        if (frame_take) begin
          case (frame_cls)
            2'b10: begin
              if (state_q == S_LEADER) begin
                state_d = S_LEADER;
              end else if (pend_valid_q) begin
                state_d = S_CHECK;
              end else begin
                state_d   = S_DONE;
                fmt_err_d = 1'b1;
              end
            end
            2'b11: begin
              // Non-field 11xxxxxx frames carry nothing for the loader.
              if (is_field) begin
                field_d = bus.byte_in[5:3];
                state_d = S_FRAME1;
              end else begin
                state_d = state_q;
              end
            end
            default: begin
              hi_d    = bus.byte_in;
              state_d = S_FRAME2;
            end
          endcase
        end else begin
          state_d = state_q;
        end
      end

      S_FRAME2: begin
        if (frame_take) begin
          if (frame_cls == 2'b00) begin
            if (pend_valid_q) begin
              // Stage the write now so address/data are stable during WRITE.
              lo_d    = bus.byte_in;
              state_d = S_WRITE;
              if (!pend_hi_q[6]) begin
                ram_wr_d   = 1'b1;
                ram_addr_d = {pend_field_q, addr_q};
                ram_data_d = pend_word;
              end else begin
                ram_wr_d   = 1'b0;
              end
            end else begin
              pend_valid_d = 1'b1;
              pend_hi_d    = hi_q;
              pend_lo_d    = bus.byte_in;
              pend_field_d = field_q;
              state_d      = S_FRAME1;
            end
          end else begin
            fmt_err_d = 1'b1;
            state_d   = S_DONE;
          end
        end else begin
          state_d = state_q;
        end
      end

      S_WRITE: begin
        if (pend_hi_q[6]) begin
          addr_d  = pend_word;
        end else begin
          addr_d  = addr_q + 12'd1;
          words_d = words_q + 12'd1;
        end
        cksum_d      = cksum_add(cksum_q, pend_hi_q, pend_lo_q);
        // No frame is accepted in WRITE, so field_q is still the field that
        // was current when the new word completed.
        pend_hi_d    = hi_q;
        pend_lo_d    = lo_q;
        pend_field_d = field_q;
        state_d      = S_FRAME1;
      end

      S_CHECK: begin
        cksum_ok_d = (pend_word == cksum_q);
        state_d    = S_DONE;
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_LEADER;
      end
    endcase

    byte_ready_d = (state_d == S_LEADER) || (state_d == S_FRAME1) ||
                   (state_d == S_FRAME2);
    busy_d       = (state_d == S_FRAME1) || (state_d == S_FRAME2) ||
                   (state_d == S_WRITE)  || (state_d == S_CHECK);
    done_d       = (state_d == S_DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LEADER;
      field_q      <= 3'd0;
      addr_q       <= 12'd0;
      cksum_q      <= 12'd0;
      words_q      <= 12'd0;
      ign_q        <= 1'b0;
      hi_q         <= 8'd0;
      lo_q         <= 8'd0;
      pend_valid_q <= 1'b0;
      pend_hi_q    <= 8'd0;
      pend_lo_q    <= 8'd0;
      pend_field_q <= 3'd0;
      ram_wr_q     <= 1'b0;
      ram_addr_q   <= 15'd0;
      ram_data_q   <= 12'd0;
      byte_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cksum_ok_q   <= 1'b0;
      fmt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      addr_q       <= addr_d;
      cksum_q      <= cksum_d;
      words_q      <= words_d;
      ign_q        <= ign_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_valid_q <= pend_valid_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_field_q <= pend_field_d;
      ram_wr_q     <= ram_wr_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cksum_ok_q   <= cksum_ok_d;
      fmt_err_q    <= fmt_err_d;
    end
  end

  assign bus.byte_ready   = byte_ready_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_data_out = ram_data_q;
  assign bus.ram_wr       = ram_wr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cksum_ok     = cksum_ok_q;
  assign bus.fmt_err      = fmt_err_q;
  assign bus.words        = words_q;

endmodule

// File: tb/tb_pdp8_binload.sv
// tb_pdp8_binload: directed tapes from the loader's test plan plus random
// BIN tapes checked against a tape-level reference model.
module tb_pdp8_binload;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  pdp8_binload_if bif();

  pdp8_binload dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [14:0] obs_addr[$];
  logic [11:0] obs_data[$];
  int          obs_cyc[$];
  int          acc_cyc[$];
  int          wr_run    = 0;
  int          max_run   = 0;
  bit          busy_seen = 1'b0;

  logic [14:0] exp_addr[$];
  logic [11:0] exp_data[$];
  bit          exp_ok;
  bit          exp_err;
  logic [11:0] exp_words;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write monitor: records every ram_wr cycle and the longest strobe run.
  initial forever begin
    @(negedge clk);
    if (bif.ram_wr === 1'b1) begin
      obs_addr.push_back(bif.ram_addr);
      obs_data.push_back(bif.ram_data_out);
      obs_cyc.push_back(cyc);
      wr_run++;
      if (wr_run > max_run) max_run = wr_run;
    end else begin
      wr_run = 0;
    end
    if (bif.busy === 1'b1) busy_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    bif.byte_valid = 1'b0;
    bif.byte_in    = 8'd0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    max_run = 0; wr_run = 0; busy_seen = 1'b0;
  endtask

  // Feed a tape frame by frame; stops early once the loader reports done.
  task automatic run_tape(input logic [7:0] t[$], input bit bubbles, input bit keep_valid);
    int wait_n;
    acc_cyc.delete();
    foreach (t[i]) begin
      if (bubbles) begin
        bif.byte_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      bif.byte_in    = t[i];
      bif.byte_valid = 1'b1;
      wait_n = 0;
      @(negedge clk);
      while (bif.byte_ready !== 1'b1 && bif.done !== 1'b1 && wait_n < 20) begin
        wait_n++;
        @(negedge clk);
      end
      if (bif.done === 1'b1) break;
      if (bif.byte_ready !== 1'b1) begin
        n_checks++;
        $display("FAIL handshake_timeout: byte_ready=%b at frame %0d, want 1", bif.byte_ready, i);
        break;
      end
      @(posedge clk);
      #1;
      acc_cyc.push_back(cyc);
    end
    if (!keep_valid) bif.byte_valid = 1'b0;
  endtask

  // Reference: parse the tape into completed words, then interpret the list.
  task automatic model_tape(input logic [7:0] t[$]);
    logic [11:0] wval[$];
    bit          worg[$];
    logic [2:0]  wfld[$];
    logic [11:0] wsum[$];
    logic [2:0]  fld = 3'd0;
    logic [7:0]  hi = 8'd0;
    bit          have_hi = 1'b0, ign = 1'b0, started = 1'b0, stop = 1'b0;
    logic [11:0] addr = 12'd0, sum = 12'd0;
    int          ncommit;
    exp_addr.delete(); exp_data.delete();
    exp_ok = 1'b0; exp_err = 1'b0; exp_words = 12'd0;
    foreach (t[i]) begin
      if (!stop) begin
        if (t[i] == 8'o377) ign = !ign;
        else if (!ign) begin
          if (have_hi) begin
            if (t[i][7:6] == 2'b00) begin
              wval.push_back({hi[5:0], t[i][5:0]});
              worg.push_back(hi[6]);
              wfld.push_back(fld);
              wsum.push_back(12'(hi) + 12'(t[i]));
              have_hi = 1'b0;
            end else begin
              exp_err = 1'b1; stop = 1'b1;
            end
          end else if (t[i][7:6] == 2'b10) begin
            if (started) begin
              stop = 1'b1;
              if (wval.size() == 0) exp_err = 1'b1;
            end
          end else if (t[i][7:6] == 2'b11) begin
            if (t[i][2:0] == 3'b000) begin fld = t[i][5:3]; started = 1'b1; end
          end else begin
            hi = t[i]; have_hi = 1'b1; started = 1'b1;
          end
        end
      end
    end
    ncommit = (wval.size() > 0) ? wval.size() - 1 : 0;
    for (int k = 0; k < ncommit; k++) begin
      sum = sum + wsum[k];
      if (worg[k]) addr = wval[k];
      else begin
        exp_addr.push_back({wfld[k], addr});
        exp_data.push_back(wval[k]);
        addr = addr + 12'd1;
        exp_words = exp_words + 12'd1;
      end
    end
    exp_ok = stop && !exp_err && (wval.size() > 0) && (wval[wval.size() - 1] == sum);
  endtask

  task automatic test_reset();
    logic [7:0] t[$];
    bif.byte_valid = 1'b0;
    bif.byte_in    = 8'd0;
    #1;
    reset = 1'b0;
    #2;
    n_checks++;
    if ({bif.byte_ready, bif.busy, bif.done, bif.cksum_ok, bif.fmt_err, bif.ram_wr} !== 6'b100000)
      $display("FAIL reset_flags: got %b want 100000",
               {bif.byte_ready, bif.busy, bif.done, bif.cksum_ok, bif.fmt_err, bif.ram_wr});
    else n_pass++;
    n_checks++;
    if (bif.words !== 12'd0) $display("FAIL reset_words: got %o want 0", bif.words);
    else n_pass++;
    n_checks++;
    if ({bif.ram_addr, bif.ram_data_out} !== 27'd0)
      $display("FAIL reset_ram_bus: got %o/%o want 0/0", bif.ram_addr, bif.ram_data_out);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    t = '{8'o200, 8'o200, 8'o200};
    run_tape(t, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({bif.busy, bif.byte_ready, bif.done} !== 3'b010)
      $display("FAIL leader_idle: busy/ready/done got %b want 010", {bif.busy, bif.byte_ready, bif.done});
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] t[$];
    do_reset();
    t = '{8'o200, 8'o200, 8'o200, 8'o102, 8'o000, 8'o074, 8'o002, 8'o002, 8'o000, 8'o200};
    run_tape(t, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_addr.size() != 1) $display("FAIL basic_nwrites: got %0d want 1", obs_addr.size());
    else n_pass++;
    n_checks++;
    if ((obs_addr.size() > 0 ? obs_addr[0] : 15'bx) !== 15'o00200 ||
        (obs_data.size() > 0 ? obs_data[0] : 12'bx) !== 12'o7402)
      $display("FAIL basic_write: got %o/%o want 00200/7402",
               obs_addr.size() > 0 ? obs_addr[0] : 15'bx, obs_data.size() > 0 ? obs_data[0] : 12'bx);
    else n_pass++;
    n_checks++;
    if ((obs_cyc.size() > 0 ? obs_cyc[0] : -1) !== (acc_cyc.size() > 8 ? acc_cyc[8] : -2))
      $display("FAIL basic_latency: write cycle %0d want %0d",
               obs_cyc.size() > 0 ? obs_cyc[0] : -1, acc_cyc.size() > 8 ? acc_cyc[8] : -2);
    else n_pass++;
    n_checks++;
    if (bif.words !== 12'd1) $display("FAIL basic_words: got %0d want 1", bif.words);
    else n_pass++;
    n_checks++;
    if ({bif.done, bif.cksum_ok, bif.fmt_err, bif.busy, bif.byte_ready} !== 5'b11000)
      $display("FAIL basic_status: done/ok/err/busy/ready got %b want 11000",
               {bif.done, bif.cksum_ok, bif.fmt_err, bif.busy, bif.byte_ready});
    else n_pass++;
    n_checks++;
    if (busy_seen !== 1'b1) $display("FAIL basic_busy_seen: got %b want 1", busy_seen);
    else n_pass++;
  endtask

  task automatic test_bad_cksum();
    logic [7:0] t[$];
    do_reset();
    t = '{8'o200, 8'o200, 8'o200, 8'o102, 8'o000, 8'o074, 8'o002, 8'o002, 8'o001, 8'o200};
    run_tape(t, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 15'o00200 || obs_data[0] !== 12'o7402)
      $display("FAIL badck_write: got %0d writes, first %o/%o, want 1 write 00200/7402",
               obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 15'bx,
               obs_data.size() > 0 ? obs_data[0] : 12'bx);
    else n_pass++;
    n_checks++;
    if ({bif.done, bif.cksum_ok, bif.fmt_err} !== 3'b100)
      $display("FAIL badck_status: done/ok/err got %b want 100", {bif.done, bif.cksum_ok, bif.fmt_err});
    else n_pass++;
  endtask

  task automatic test_wrap_field();
    logic [7:0]  t[$];
    logic [14:0] wa[4] = '{15'o07777, 15'o00000, 15'o00001, 15'o10000};
    logic [11:0] wd[4] = '{12'o1111, 12'o2222, 12'o3333, 12'o4444};
    do_reset();
    // checksum 0662 = sum of all origin/data frame bytes
    t = '{8'o200, 8'o200, 8'o177, 8'o077, 8'o011, 8'o011, 8'o022, 8'o022, 8'o033, 8'o033,
          8'o310, 8'o100, 8'o000, 8'o044, 8'o044, 8'o006, 8'o062, 8'o200};
    run_tape(t, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_addr.size() != 4) $display("FAIL wrap_nwrites: got %0d want 4", obs_addr.size());
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ((obs_addr.size() > k ? obs_addr[k] : 15'bx) !== wa[k] ||
          (obs_data.size() > k ? obs_data[k] : 12'bx) !== wd[k])
        $display("FAIL wrap_write%0d: got %o/%o want %o/%o", k,
                 obs_addr.size() > k ? obs_addr[k] : 15'bx, obs_data.size() > k ? obs_data[k] : 12'bx,
                 wa[k], wd[k]);
      else n_pass++;
    end
    n_checks++;
    if ({bif.words, bif.done, bif.cksum_ok, bif.fmt_err} !== {12'd4, 3'b110})
      $display("FAIL wrap_status: words=%0d done/ok/err=%b want 4 110",
               bif.words, {bif.done, bif.cksum_ok, bif.fmt_err});
    else n_pass++;
  endtask

  task automatic test_rubout();
    logic [7:0] t[$];
    do_reset();
    t = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o074, 8'o002, 8'o377, 8'o123, 8'o377,
          8'o011, 8'o022, 8'o002, 8'o033, 8'o200};
    run_tape(t, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 15'o00200 || obs_data[0] !== 12'o7402 ||
        obs_addr[1] !== 15'o00201 || obs_data[1] !== 12'o1122)
      $display("FAIL rubout_writes: got %0d writes, want 00200/7402 00201/1122", obs_addr.size());
    else n_pass++;
    n_checks++;
    if ({bif.words, bif.cksum_ok, bif.fmt_err} !== {12'd2, 2'b10})
      $display("FAIL rubout_status: words=%0d ok/err=%b want 2 10", bif.words, {bif.cksum_ok, bif.fmt_err});
    else n_pass++;
  endtask

  task automatic test_fmt_err();
    logic [7:0] t[$];
    do_reset();
    t = '{8'o200, 8'o102, 8'o102, 8'o000, 8'o074, 8'o002, 8'o200};
    run_tape(t, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bif.fmt_err, bif.done, bif.byte_ready, bif.busy, bif.cksum_ok} !== 5'b11000)
      $display("FAIL fmterr_status: err/done/ready/busy/ok got %b want 11000",
               {bif.fmt_err, bif.done, bif.byte_ready, bif.busy, bif.cksum_ok});
    else n_pass++;
    n_checks++;
    if (obs_addr.size() != 0 || bif.words !== 12'd0)
      $display("FAIL fmterr_writes: got %0d writes words=%0d want 0 0", obs_addr.size(), bif.words);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] t[$];
    do_reset();
    t = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o074};
    run_tape(t, 1'b0, 1'b1);
    n_checks++;
    if (bif.busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", bif.busy);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bif.ram_wr, bif.busy, bif.byte_ready, bif.done, bif.words} !== {4'b0010, 12'd0})
      $display("FAIL midrst_async: wr/busy/ready/done=%b words=%0d want 0010 0",
               {bif.ram_wr, bif.busy, bif.byte_ready, bif.done}, bif.words);
    else n_pass++;
    @(posedge clk);
    #1;
    bif.byte_valid = 1'b0;
    reset = 1'b1;
    n_checks++;
    if (obs_addr.size() != 0) $display("FAIL midrst_nowrite: got %0d writes want 0", obs_addr.size());
    else n_pass++;
    t = '{8'o200, 8'o200, 8'o200, 8'o102, 8'o000, 8'o074, 8'o002, 8'o002, 8'o000, 8'o200};
    run_tape(t, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 15'o00200 || obs_data[0] !== 12'o7402 ||
        {bif.cksum_ok, bif.fmt_err, bif.words} !== {2'b10, 12'd1})
      $display("FAIL midrst_fresh_tape: %0d writes ok/err=%b words=%0d want 1 10 1",
               obs_addr.size(), {bif.cksum_ok, bif.fmt_err}, bif.words);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0]  t[$];
    logic [11:0] s, v, ck;
    logic [7:0]  hb, lb;
    bit          org;
    int          nw;
    for (int it = 0; it < 25; it++) begin
      do_reset();
      t.delete();
      s = 12'd0;
      repeat ($urandom_range(1, 3)) t.push_back(8'o200);
      nw = $urandom_range(1, 7);
      for (int w = 0; w < nw; w++) begin
        case ($urandom_range(0, 5))
          0: t.push_back({2'b11, 3'($urandom_range(0, 7)), 3'b000});
          1: begin
            t.push_back(8'o377);
            t.push_back(8'($urandom_range(0, 254)));
            t.push_back(8'o377);
          end
          default: ;
        endcase
        v   = 12'($urandom);
        org = (w == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
        hb  = {1'b0, org, v[11:6]};
        lb  = {2'b00, v[5:0]};
        t.push_back(hb);
        t.push_back(lb);
        s = s + 12'(hb) + 12'(lb);
      end
      ck = s;
      if ($urandom_range(0, 3) == 0) ck = ck + 12'd1;
      t.push_back({2'b00, ck[11:6]});
      t.push_back({2'b00, ck[5:0]});
      t.push_back(8'o200);
      model_tape(t);
      run_tape(t, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      n_checks++;
      if (obs_addr.size() != exp_addr.size())
        $display("FAIL rand%0d_nwrites: got %0d want %0d", it, obs_addr.size(), exp_addr.size());
      else n_pass++;
      for (int k = 0; k < exp_addr.size(); k++) begin
        n_checks++;
        if ((obs_addr.size() > k ? obs_addr[k] : 15'bx) !== exp_addr[k] ||
            (obs_data.size() > k ? obs_data[k] : 12'bx) !== exp_data[k])
          $display("FAIL rand%0d_write%0d: got %o/%o want %o/%o", it, k,
                   obs_addr.size() > k ? obs_addr[k] : 15'bx, obs_data.size() > k ? obs_data[k] : 12'bx,
                   exp_addr[k], exp_data[k]);
        else n_pass++;
      end
      n_checks++;
      if ({bif.words, bif.done, bif.cksum_ok, bif.fmt_err} !== {exp_words, 1'b1, exp_ok, exp_err})
        $display("FAIL rand%0d_status: words=%0d done/ok/err=%b want %0d 1%b%b", it,
                 bif.words, {bif.done, bif.cksum_ok, bif.fmt_err}, exp_words, exp_ok, exp_err);
      else n_pass++;
      n_checks++;
      if (max_run > 1) $display("FAIL rand%0d_wr_pulse: ram_wr high %0d cycles want 1", it, max_run);
      else n_pass++;
    end
  endtask

  initial begin
    bif.byte_in    = 8'd0;
    bif.byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_bad_cksum();
    test_wrap_field();
    test_rubout();
    test_fmt_err();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
